ram_loader: RTL and testbench

- Bus initiator that fills the program RAM through its addr_enable/write_enable/enable interface, in place of a pre-built prog.list image.
- Accepts a word stream over a valid/ready handshake and writes it to consecutive addresses from 0.
- Reads the image back and checks it against a running checksum.
- Holds the CPU off the bus while working; sits between the host/UART front end and the RAM.

---
 rtl/bbcpu_pkg.sv | 24 ++
 rtl/ram_bus_driver.sv | 72 +++++++
 rtl/ram_loader.sv | 189 ++++++++++++++++++
 tb/tb_ram_loader.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbcpu_pkg.sv
// Shared types and default sizes for the loader and the program RAM.
package bbcpu_pkg;

  localparam int BBCPU_ADDRESS_WIDTH = 4;
  localparam int BBCPU_WIDTH         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ADDR,
    ST_WRITE,
    ST_VADDR,
    ST_VREAD,
    ST_CHECK
  } loader_state_e;

  typedef enum logic [1:0] {
    CMD_NOP,
    CMD_ADDR,
    CMD_WRITE,
    CMD_READ
  } bus_cmd_e;

endpackage

// File: rtl/ram_bus_driver.sv
// Registers the RAM strobes and bus value from a one-hot-by-construction command,
// so at most one strobe is ever high and oe always accompanies it.
module ram_bus_driver
  import bbcpu_pkg::*;
#(
  parameter int WIDTH = BBCPU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  bus_cmd_e         cmd_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] bus_out_o,
  output logic             oe_o,
  output logic             enable_o,
  output logic             addr_enable_o,
  output logic             write_enable_o
);

  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             oe_q, oe_d;
  logic             enable_q, enable_d;
  logic             addr_enable_q, addr_enable_d;
  logic             write_enable_q, write_enable_d;

  always_comb begin
    bus_out_d      = '0;
    oe_d           = 1'b0;
    enable_d       = 1'b0;
    addr_enable_d  = 1'b0;
    write_enable_d = 1'b0;
    case (cmd_i)
      CMD_ADDR: begin
        oe_d          = 1'b1;
        addr_enable_d = 1'b1;
        bus_out_d     = value_i;
      end
      CMD_WRITE: begin
        oe_d           = 1'b1;
        write_enable_d = 1'b1;
        bus_out_d      = value_i;
      end
      CMD_READ: begin
        oe_d     = 1'b1;
        enable_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_out_q      <= '0;
      oe_q           <= 1'b0;
      enable_q       <= 1'b0;
      addr_enable_q  <= 1'b0;
      write_enable_q <= 1'b0;
    end else begin
      bus_out_q      <= bus_out_d;
      oe_q           <= oe_d;
      enable_q       <= enable_d;
      addr_enable_q  <= addr_enable_d;
      write_enable_q <= write_enable_d;
    end
  end

  assign bus_out_o      = bus_out_q;
  assign oe_o           = oe_q;
  assign enable_o       = enable_q;
  assign addr_enable_o  = addr_enable_q;
  assign write_enable_o = write_enable_q;

endmodule

// File: rtl/ram_loader.sv
// Streams an image into program RAM from address 0, reads it back and compares checksums.
//  state  | meaning
//  IDLE   | waiting for start; CPU released
//  WAIT   | in_ready high, waiting for a stream word
//  ADDR   | address strobe for the current write
//  WRITE  | write strobe with the captured word
//  VADDR  | address strobe for the verify read
//  VREAD  | read enable; sample read data into rsum
//  CHECK  | done/error published; back to IDLE
module ram_loader
  import bbcpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = BBCPU_ADDRESS_WIDTH,
  parameter int WIDTH         = BBCPU_WIDTH,
  parameter int MEMORY_SIZE   = 1 << ADDRESS_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       ram_bus_in,
  output logic [WIDTH-1:0]       ram_bus_out,
  output logic                   ram_bus_oe,
  output logic                   ram_enable,
  output logic                   ram_addr_enable,
  output logic                   ram_write_enable,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error,
  output logic [ADDRESS_WIDTH:0] word_count
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = ADDRESS_WIDTH'(MEMORY_SIZE - 1);

  loader_state_e            state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] vaddr_q, vaddr_d;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;
  logic [WIDTH-1:0]         data_q, data_d;
  logic                     last_q, last_d;
  logic [WIDTH-1:0]         wsum_q, wsum_d;
  logic [WIDTH-1:0]         rsum_q, rsum_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     hold_q, hold_d;

  bus_cmd_e                 cmd;
  logic [WIDTH-1:0]         cmd_value;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    vaddr_d = vaddr_q;
    count_d = count_q;
    data_d  = data_q;
    last_d  = last_q;
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
    done_d  = done_q;
    error_d = error_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          done_d  = 1'b0;
          error_d = 1'b0;
          addr_d  = '0;
          vaddr_d = '0;
          count_d = '0;
          wsum_d  = '0;
          rsum_d  = '0;
          hold_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (in_valid) begin
          data_d  = in_data;
          last_d  = in_last;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_WRITE;
      ST_WRITE: begin
        wsum_d  = wsum_q + data_q;
        count_d = count_q + 1'b1;
        // Full check happens before the increment so the address never wraps.
        if (last_q || (addr_q == ADDR_LAST)) begin
          vaddr_d = '0;
          state_d = ST_VADDR;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_VADDR: state_d = ST_VREAD;
      ST_VREAD: begin
        rsum_d = rsum_q + ram_bus_in;
        if ({1'b0, vaddr_q} == (count_q - 1'b1)) begin
          // Flags are registered on entry so they are visible during CHECK.
          state_d = ST_CHECK;
          done_d  = 1'b1;
          error_d = (rsum_d != wsum_q);
          hold_d  = 1'b0;
        end else begin
          vaddr_d = vaddr_q + 1'b1;
          state_d = ST_VADDR;
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered, so the command is derived from the state being entered.
  always_comb begin
    cmd       = CMD_NOP;
    cmd_value = '0;
    case (state_d)
      ST_ADDR: begin
        cmd       = CMD_ADDR;
        cmd_value = WIDTH'(addr_d);
      end
      ST_WRITE: begin
        cmd       = CMD_WRITE;
        cmd_value = data_d;
      end
      ST_VADDR: begin
        cmd       = CMD_ADDR;
        cmd_value = WIDTH'(vaddr_d);
      end
      ST_VREAD: cmd = CMD_READ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      vaddr_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      wsum_q  <= '0;
      rsum_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vaddr_q <= vaddr_d;
      count_q <= count_d;
      data_q  <= data_d;
      last_q  <= last_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  ram_bus_driver #(
    .WIDTH(WIDTH)
  ) u_bus (
    .clk           (clk),
    .rst           (rst),
    .cmd_i         (cmd),
    .value_i       (cmd_value),
    .bus_out_o     (ram_bus_out),
    .oe_o          (ram_bus_oe),
    .enable_o      (ram_enable),
    .addr_enable_o (ram_addr_enable),
    .write_enable_o(ram_write_enable)
  );

  assign in_ready   = (state_q == ST_WAIT);
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: behavioural RAM, write scoreboard and bus-rule monitor.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] ram_bus_in;
  logic [7:0] ram_bus_out;
  logic       ram_bus_oe;
  logic       ram_enable;
  logic       ram_addr_enable;
  logic       ram_write_enable;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [4:0] word_count;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic [7:0]  mem [16];
  logic [3:0]  lat_addr;
  logic        clr_req = 1'b0;
  logic        flip    = 1'b0;
  logic [11:0] exp_q[$];
  logic [3:0]  next_addr;
  logic [7:0]  img[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_loader dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .ram_bus_in      (ram_bus_in),
    .ram_bus_out     (ram_bus_out),
    .ram_bus_oe      (ram_bus_oe),
    .ram_enable      (ram_enable),
    .ram_addr_enable (ram_addr_enable),
    .ram_write_enable(ram_write_enable),
    .cpu_hold        (cpu_hold),
    .done            (done),
    .error           (error),
    .word_count      (word_count)
  );

  // RAM model: write has priority over address latch; read is combinational.
  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (ram_write_enable) begin
      mem[lat_addr] <= ram_bus_out;
    end else if (ram_addr_enable) begin
      lat_addr <= ram_bus_out[3:0];
    end
  end

  assign ram_bus_in = ram_enable ? (mem[lat_addr] ^ {7'b0, flip && (lat_addr == 4'd1)}) : 8'h00;

  task automatic monitor();
    logic [11:0] e;
    int n;
    forever begin
      @(negedge clk);
      if (rst) begin
        n = int'(ram_enable) + int'(ram_addr_enable) + int'(ram_write_enable);
        vectors++;
        if (n > 1 || (n == 1 && !ram_bus_oe) || (!ram_bus_oe && ram_bus_out !== 8'h00) ||
            (in_ready && ram_bus_oe)) begin
          miscompares++;
          $display("FAIL bus_rules t=%0t en/ae/we=%b%b%b oe=%b out=%h ready=%b; required <=1 strobe, oe with strobe, out=0 when oe=0, ready only off-bus",
                   $time, ram_enable, ram_addr_enable, ram_write_enable, ram_bus_oe, ram_bus_out, in_ready);
        end
        if (ram_write_enable) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write t=%0t addr=%h data=%h; required no write", $time, lat_addr, ram_bus_out);
          end else begin
            e = exp_q.pop_front();
            if ({lat_addr, ram_bus_out} !== e) begin
              miscompares++;
              $display("FAIL write_data t=%0t got addr=%h data=%h; required addr=%h data=%h",
                       $time, lat_addr, ram_bus_out, e[11:8], e[7:0]);
            end
          end
        end
      end
    end
  endtask

  task automatic clear_ram();
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    next_addr = 4'd0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l, input int gap, output int acc_edge);
    int budget;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    budget   = 200;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    vectors++;
    acc_edge = cyc + 1;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL accept_timeout word=%h in_ready=%b; required 1", d, in_ready);
    end else begin
      exp_q.push_back({next_addr, d});
      next_addr++;
    end
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_image(input logic use_last, input int gap, output int first_acc);
    int acc;
    first_acc = 0;
    for (int i = 0; i < img.size(); i++) begin
      send_word(img[i], use_last && (i == img.size() - 1), gap, acc);
      if (i == 0) first_acc = acc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 300;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL done_timeout done=%b; required 1", done);
    end
  endtask

  task automatic check_image(input string name);
    for (int i = 0; i < img.size() && i < 16; i++) begin
      vectors++;
      if (mem[i] !== img[i]) begin
        miscompares++;
        $display("FAIL %s_ram[%0d] got %h; required %h", name, i, mem[i], img[i]);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending_writes got %0d; required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    #12;
    vectors++;
    if ({in_ready, ram_bus_out, ram_bus_oe, ram_enable, ram_addr_enable, ram_write_enable,
         cpu_hold, done, error, word_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs ready=%b out=%h oe=%b en/ae/we=%b%b%b hold=%b done=%b err=%b cnt=%0d; required all 0",
               in_ready, ram_bus_out, ram_bus_oe, ram_enable, ram_addr_enable, ram_write_enable,
               cpu_hold, done, error, word_count);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int acc0;
    clear_ram();
    img = '{8'h3A, 8'h01, 8'hFF};
    do_start();
    vectors++;
    if (cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_hold hold=%b ready=%b; required 1 1", cpu_hold, in_ready);
    end
    send_image(1'b1, 0, acc0);
    while (cyc < acc0 + 13) @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_early done=%b at edge %0d; required 0", done, cyc - acc0);
    end
    @(negedge clk);
    vectors++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      miscompares++;
      $display("FAIL basic_latency done/err/hold=%b%b%b at edge %0d; required 100", done, error, cpu_hold, cyc - acc0);
    end
    vectors++;
    if (word_count !== 5'd3) begin
      miscompares++;
      $display("FAIL basic_count got %0d; required 3", word_count);
    end
    check_image("basic");
  endtask

  task automatic test_stalls();
    int acc0;
    clear_ram();
    img = '{8'h3A, 8'h01, 8'hFF};
    do_start();
    send_image(1'b1, 5, acc0);
    wait_done();
    vectors++;
    if ({error, cpu_hold, word_count} !== {2'b00, 5'd3}) begin
      miscompares++;
      $display("FAIL stall_status err=%b hold=%b cnt=%0d; required 0 0 3", error, cpu_hold, word_count);
    end
    check_image("stall");
  endtask

  task automatic test_full();
    int acc0;
    int ready_seen = 0;
    int budget = 200;
    clear_ram();
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'(i));
    do_start();
    send_image(1'b0, 0, acc0);
    in_valid = 1'b1;
    in_data  = 8'h10;
    while (!done && budget > 0) begin
      if (in_ready) ready_seen++;
      @(negedge clk);
      budget--;
    end
    for (int k = 0; k < 4; k++) begin
      in_data = 8'h10 + 8'(k);
      if (in_ready) ready_seen++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (ready_seen != 0) begin
      miscompares++;
      $display("FAIL full_extra_ready got %0d ready cycles; required 0", ready_seen);
    end
    vectors++;
    if ({done, error, word_count} !== {2'b10, 5'd16}) begin
      miscompares++;
      $display("FAIL full_status done=%b err=%b cnt=%0d; required 1 0 16", done, error, word_count);
    end
    check_image("full");
  endtask

  task automatic test_mismatch();
    int acc0;
    clear_ram();
    img = '{8'h11, 8'h22, 8'h33};
    flip = 1'b1;
    do_start();
    send_image(1'b1, 0, acc0);
    wait_done();
    vectors++;
    if ({done, error, cpu_hold} !== 3'b110) begin
      miscompares++;
      $display("FAIL mismatch_status done/err/hold=%b%b%b; required 110", done, error, cpu_hold);
    end
    flip = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midload();
    int acc0;
    clear_ram();
    img = '{8'hA1, 8'hA2};
    do_start();
    send_image(1'b0, 0, acc0);
    @(negedge clk);
    vectors++;
    if (ram_write_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL midload_second_write we=%b; required 1", ram_write_enable);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({in_ready, ram_bus_out, ram_bus_oe, ram_enable, ram_addr_enable, ram_write_enable,
         cpu_hold, done, error} !== '0) begin
      miscompares++;
      $display("FAIL midload_reset ready=%b out=%h oe=%b en/ae/we=%b%b%b hold=%b done=%b err=%b; required all 0",
               in_ready, ram_bus_out, ram_bus_oe, ram_enable, ram_addr_enable, ram_write_enable,
               cpu_hold, done, error);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    clear_ram();
    img = '{8'h5C, 8'h07, 8'hE3, 8'h90, 8'h41};
    do_start();
    send_image(1'b1, 0, acc0);
    wait_done();
    vectors++;
    if ({error, word_count} !== {1'b0, 5'd5}) begin
      miscompares++;
      $display("FAIL midload_reload err=%b cnt=%0d; required 0 5", error, word_count);
    end
    check_image("reload");
  endtask

  task automatic test_ignored_start();
    int acc0;
    int budget = 100;
    clear_ram();
    img = '{8'h80, 8'h7F, 8'h12};
    do_start();
    send_image(1'b1, 0, acc0);
    while (!ram_enable && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    vectors++;
    if (ram_enable !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL ignstart_vread en=%b done=%b err=%b; required 1 0 0", ram_enable, done, error);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    vectors++;
    if ({error, word_count} !== {1'b0, 5'd3}) begin
      miscompares++;
      $display("FAIL ignstart_status err=%b cnt=%0d; required 0 3", error, word_count);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if ({in_ready, cpu_hold, done} !== 3'b001) begin
      miscompares++;
      $display("FAIL ignstart_restart ready=%b hold=%b done=%b; required 0 0 1", in_ready, cpu_hold, done);
    end
    check_image("ignstart");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_stalls();
    test_full();
    test_mismatch();
    test_reset_midload();
    test_ignored_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
